// File: rtl/trap_controller.sv
// ---------------------------------------------------------------------------
// trap_controller
//
// Execute-stage controller for a single-issue core. It sequences the
// multi-cycle operations (LSU access, jump, taken branch) and arbitrates
// traps: ecall, illegal instruction, LSU error, LSU timeout and NUM_IRQ
// prioritised interrupts. A trap selects PC_EXCEPTION, requests an EPC save
// and drives the trap-table target, which is either one entry per cause
// (vectored) or a single shared entry (direct). ebreak parks the controller
// in an absorbing HALT state that only a reset leaves.
//
// Ports
//   clk             clock
//   rst_n           synchronous active-low reset
//   inst_valid_i    decoded instruction valid
//   jump_inst_i     instruction is a jump
//   branch_inst_i   instruction is a conditional branch
//   ecall_inst_i    instruction is ecall
//   ebreak_inst_i   instruction is ebreak
//   mret_inst_i     instruction is mret
//   illegal_inst_i  decoder flagged an illegal instruction
//   comp_result_i   branch condition true (branch taken)
//   lsu_en_i        instruction uses the LSU
//   lsu_done_i      LSU access complete
//   lsu_err_i       LSU access error
//   irq_i           level interrupt requests
//   irq_en_i        per-line interrupt enables (mie)
//   global_ie_i     global interrupt enable (mstatus.MIE)
//   rf_wen_o        register file write permitted
//   retire_o        instruction retires this cycle
//   pc_mux_sel_o    PC source: branch/jump, exception or EPC
//   exc_pc_o        trap target address
//   save_epc_o      latch EPC this cycle
//   target_valid_o  PC target valid this cycle
//   irq_ack_o       one-hot acknowledge of the interrupt being taken
//   mcause_o        cause of the most recent trap (registered)
//   halt_o          core halted (registered)
//   cycle_count_o   cycles spent in MULTI_CYCLE (registered, saturating)
// ---------------------------------------------------------------------------
module trap_controller #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    NUM_IRQ     = 4,
    parameter logic [ADDR_WIDTH-1:0] VEC_BASE    = '0,
    parameter bit                    VECTORED    = 1'b1,
    parameter int                    LSU_TIMEOUT = 16,
    parameter int                    CNT_W       = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inst_valid_i,
    input  logic                  jump_inst_i,
    input  logic                  branch_inst_i,
    input  logic                  ecall_inst_i,
    input  logic                  ebreak_inst_i,
    input  logic                  mret_inst_i,
    input  logic                  illegal_inst_i,
    input  logic                  comp_result_i,
    input  logic                  lsu_en_i,
    input  logic                  lsu_done_i,
    input  logic                  lsu_err_i,
    input  logic [NUM_IRQ-1:0]    irq_i,
    input  logic [NUM_IRQ-1:0]    irq_en_i,
    input  logic                  global_ie_i,
    output logic                  rf_wen_o,
    output logic                  retire_o,
    output logic [1:0]            pc_mux_sel_o,
    output logic [ADDR_WIDTH-1:0] exc_pc_o,
    output logic                  save_epc_o,
    output logic                  target_valid_o,
    output logic [NUM_IRQ-1:0]    irq_ack_o,
    output logic [5:0]            mcause_o,
    output logic                  halt_o,
    output logic [CNT_W-1:0]      cycle_count_o
);

    // PC mux encodings shared with the fetch-stage PC multiplexer.
    localparam logic [1:0] PC_BRANCH_JUMP = 2'd0;
    localparam logic [1:0] PC_EXCEPTION   = 2'd1;
    localparam logic [1:0] PC_EPC         = 2'd2;

    // Trap cause codes.
    localparam logic [5:0] CAUSE_ECALL    = 6'd1;
    localparam logic [5:0] CAUSE_ILLEGAL  = 6'd2;
    localparam logic [5:0] CAUSE_LSU_ERR  = 6'd4;
    localparam logic [5:0] CAUSE_LSU_TOUT = 6'd5;
    localparam logic [5:0] CAUSE_IRQ_BASE = 6'd16;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(LSU_TIMEOUT);
    localparam bit               TIMEOUT_EN  = (LSU_TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        MULTI_CYCLE = 2'd1,
        HALT        = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       mcause_q;
    logic             halt_q;
    logic [CNT_W-1:0] cnt_q;

    logic             trap;
    logic [5:0]       trap_code;

    // ------------------------------------------------------------------
    // Interrupt qualification and lowest-index-first priority encoding
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] irq_pend;
    logic               irq_hit;
    logic [3:0]         irq_idx;

    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_irq_pend
            assign irq_pend[gi] = irq_i[gi] & irq_en_i[gi] & global_ie_i;
        end
    endgenerate

    // Scanning from the top down lets the lowest pending index overwrite
    // any higher one, so it wins.
    always_comb begin
        irq_hit = 1'b0;
        irq_idx = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (irq_pend[k]) begin
                irq_hit = 1'b1;
                irq_idx = 4'(k);
            end
        end
    end

    // The timeout fires on the cycle the counter reaches the limit while
    // the LSU is still busy.
    logic timeout_hit;
    assign timeout_hit = TIMEOUT_EN && (cnt_q == TIMEOUT_CNT);

    // ------------------------------------------------------------------
    // Next state and combinational outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        trap           = 1'b0;
        trap_code      = '0;
        rf_wen_o       = 1'b0;
        retire_o       = 1'b0;
        pc_mux_sel_o   = PC_BRANCH_JUMP;
        exc_pc_o       = '0;
        save_epc_o     = 1'b0;
        target_valid_o = 1'b0;
        irq_ack_o      = '0;

        unique case (state_q)
            IDLE: begin
                if (inst_valid_i) begin
                    if (irq_hit) begin
                        // Interrupts pre-empt even an LSU or jump instruction.
                        trap      = 1'b1;
                        trap_code = CAUSE_IRQ_BASE + {2'b00, irq_idx};
                        irq_ack_o = NUM_IRQ'(1) << irq_idx;
                    end else if (lsu_en_i && lsu_err_i) begin
                        trap      = 1'b1;
                        trap_code = CAUSE_LSU_ERR;
                    end else if (lsu_en_i) begin
                        state_d = MULTI_CYCLE;
                    end else if (jump_inst_i) begin
                        rf_wen_o = 1'b1;
                        state_d  = MULTI_CYCLE;
                    end else if (branch_inst_i) begin
                        rf_wen_o = 1'b1;
                        if (comp_result_i) begin
                            state_d = MULTI_CYCLE;
                        end else begin
                            retire_o = 1'b1;
                        end
                    end else if (mret_inst_i) begin
                        pc_mux_sel_o   = PC_EPC;
                        target_valid_o = 1'b1;
                        retire_o       = 1'b1;
                    end else if (ecall_inst_i) begin
                        trap      = 1'b1;
                        trap_code = CAUSE_ECALL;
                    end else if (illegal_inst_i) begin
                        trap      = 1'b1;
                        trap_code = CAUSE_ILLEGAL;
                    end else if (ebreak_inst_i) begin
                        state_d = HALT;
                    end else begin
                        rf_wen_o = 1'b1;
                        retire_o = 1'b1;
                    end
                end
            end

            MULTI_CYCLE: begin
                // Interrupts are deliberately not sampled here; they stay
                // pending and are taken once back in IDLE.
                if (inst_valid_i) begin
                    if (lsu_en_i) begin
                        if (!lsu_done_i) begin
                            if (timeout_hit) begin
                                trap      = 1'b1;
                                trap_code = CAUSE_LSU_TOUT;
                                state_d   = IDLE;
                            end
                        end else begin
                            // A late error alongside completion is dropped.
                            rf_wen_o = 1'b1;
                            retire_o = 1'b1;
                            state_d  = IDLE;
                        end
                    end else if (jump_inst_i || branch_inst_i) begin
                        target_valid_o = 1'b1;
                        rf_wen_o       = 1'b1;
                        retire_o       = 1'b1;
                        state_d        = IDLE;
                    end else begin
                        // Nothing left to wait for: drop back without retiring.
                        state_d = IDLE;
                    end
                end
            end

            HALT: begin
                state_d = HALT;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (trap) begin
            pc_mux_sel_o   = PC_EXCEPTION;
            target_valid_o = 1'b1;
            save_epc_o     = 1'b1;
            rf_wen_o       = 1'b0;
            retire_o       = 1'b0;
            exc_pc_o       = VECTORED ? (VEC_BASE + ADDR_WIDTH'({trap_code, 2'b00}))
                                      : VEC_BASE;
        end
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcause_q <= '0;
            halt_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (trap) begin
                mcause_q <= trap_code;
            end
            if (state_d == HALT) begin
                halt_q <= 1'b1;
            end
            if (state_d == MULTI_CYCLE) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (state_d == IDLE) begin
                cnt_q <= '0;
            end
        end
    end

    assign mcause_o      = mcause_q;
    assign halt_o        = halt_q;
    assign cycle_count_o = cnt_q;

endmodule

// File: tb/tb_trap_controller.sv
module tb_trap_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_valid_i, jump_inst_i, branch_inst_i, ecall_inst_i;
    logic        ebreak_inst_i, mret_inst_i, illegal_inst_i, comp_result_i;
    logic        lsu_en_i, lsu_done_i, lsu_err_i, global_ie_i;
    logic [3:0]  irq_i, irq_en_i;

    // Instance A: vectored table at 0x100
    logic        a_rf_wen, a_retire, a_save_epc, a_tvalid, a_halt;
    logic [1:0]  a_pc_mux;
    logic [31:0] a_exc_pc;
    logic [3:0]  a_ack;
    logic [5:0]  a_mcause;
    logic [4:0]  a_cnt;

    // Instance B: direct table at 0x200
    logic        b_rf_wen, b_retire, b_save_epc, b_tvalid, b_halt;
    logic [1:0]  b_pc_mux;
    logic [31:0] b_exc_pc;
    logic [3:0]  b_ack;
    logic [5:0]  b_mcause;
    logic [4:0]  b_cnt;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [1:0] PC_BRANCH_JUMP = 2'd0;
    localparam logic [1:0] PC_EXCEPTION   = 2'd1;
    localparam logic [1:0] PC_EPC         = 2'd2;

    trap_controller #(.ADDR_WIDTH(32), .NUM_IRQ(4), .VEC_BASE(32'h100), .VECTORED(1'b1),
                      .LSU_TIMEOUT(16), .CNT_W(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .inst_valid_i(inst_valid_i),
        .jump_inst_i(jump_inst_i), .branch_inst_i(branch_inst_i),
        .ecall_inst_i(ecall_inst_i), .ebreak_inst_i(ebreak_inst_i),
        .mret_inst_i(mret_inst_i), .illegal_inst_i(illegal_inst_i),
        .comp_result_i(comp_result_i), .lsu_en_i(lsu_en_i),
        .lsu_done_i(lsu_done_i), .lsu_err_i(lsu_err_i), .irq_i(irq_i),
        .irq_en_i(irq_en_i), .global_ie_i(global_ie_i),
        .rf_wen_o(a_rf_wen), .retire_o(a_retire), .pc_mux_sel_o(a_pc_mux),
        .exc_pc_o(a_exc_pc), .save_epc_o(a_save_epc), .target_valid_o(a_tvalid),
        .irq_ack_o(a_ack), .mcause_o(a_mcause), .halt_o(a_halt),
        .cycle_count_o(a_cnt)
    );

    trap_controller #(.ADDR_WIDTH(32), .NUM_IRQ(4), .VEC_BASE(32'h200), .VECTORED(1'b0),
                      .LSU_TIMEOUT(16), .CNT_W(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .inst_valid_i(inst_valid_i),
        .jump_inst_i(jump_inst_i), .branch_inst_i(branch_inst_i),
        .ecall_inst_i(ecall_inst_i), .ebreak_inst_i(ebreak_inst_i),
        .mret_inst_i(mret_inst_i), .illegal_inst_i(illegal_inst_i),
        .comp_result_i(comp_result_i), .lsu_en_i(lsu_en_i),
        .lsu_done_i(lsu_done_i), .lsu_err_i(lsu_err_i), .irq_i(irq_i),
        .irq_en_i(irq_en_i), .global_ie_i(global_ie_i),
        .rf_wen_o(b_rf_wen), .retire_o(b_retire), .pc_mux_sel_o(b_pc_mux),
        .exc_pc_o(b_exc_pc), .save_epc_o(b_save_epc), .target_valid_o(b_tvalid),
        .irq_ack_o(b_ack), .mcause_o(b_mcause), .halt_o(b_halt),
        .cycle_count_o(b_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs and checks happen mid-cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_valid_i = 0; jump_inst_i = 0; branch_inst_i = 0; ecall_inst_i = 0;
        ebreak_inst_i = 0; mret_inst_i = 0; illegal_inst_i = 0; comp_result_i = 0;
        lsu_en_i = 0; lsu_done_i = 0; lsu_err_i = 0; global_ie_i = 0;
        irq_i = '0; irq_en_i = '0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        cyc();
        cyc();
        // Reset state
        check("rst_halt", 32'(a_halt), 32'd0);
        check("rst_mcause", 32'(a_mcause), 32'd0);
        check("rst_cnt", 32'(a_cnt), 32'd0);
        check("rst_defaults", {a_rf_wen, a_retire, a_tvalid, a_save_epc, a_pc_mux}, 32'd0);
        $display("reset: halt=%0d mcause=%0d cnt=%0d", a_halt, a_mcause, a_cnt);

        // Interrupt 1 of 0110 wins
        rst_n = 1'b1;
        inst_valid_i = 1; irq_i = 4'b0110; irq_en_i = 4'b1111; global_ie_i = 1;
        #2;
        check("irq_ack", 32'(a_ack), 32'h2);
        check("irq_exc_pc_vec", a_exc_pc, 32'h144);
        check("irq_exc_pc_dir", b_exc_pc, 32'h200);
        check("irq_retire", 32'(a_retire), 32'd0);
        check("irq_ctrl", {a_pc_mux, a_tvalid, a_save_epc, a_rf_wen}, {27'd0, PC_EXCEPTION, 3'b110});
        $display("irq trap: ack=%b exc_pc=%h", a_ack, a_exc_pc);
        cyc();
        check("irq_mcause", 32'(a_mcause), 32'd17);

        // Same request with global enable clear: plain retire
        global_ie_i = 0;
        #2;
        check("noirq_ack", 32'(a_ack), 32'd0);
        check("noirq_ret_wen", {a_retire, a_rf_wen, a_tvalid}, 32'b110);
        $display("masked irq: retire=%0d rf_wen=%0d", a_retire, a_rf_wen);
        cyc();

        // LSU access completing on the third cycle
        clear_inputs();
        inst_valid_i = 1; lsu_en_i = 1;
        #2;
        check("lsu_issue", {a_rf_wen, a_retire}, 32'd0);
        cyc();
        check("lsu_w1_cnt", 32'(a_cnt), 32'd1);
        check("lsu_w1", {a_rf_wen, a_retire}, 32'd0);
        irq_i = 4'b0001; irq_en_i = 4'b0001; global_ie_i = 1;  // must not be taken here
        cyc();
        check("lsu_w2_cnt", 32'(a_cnt), 32'd2);
        check("lsu_w2", {a_rf_wen, a_retire, a_save_epc}, 32'd0);
        check("lsu_w2_noack", 32'(a_ack), 32'd0);
        irq_i = '0; irq_en_i = '0; global_ie_i = 0;
        lsu_done_i = 1; lsu_err_i = 1;  // error with completion is ignored
        #2;
        check("lsu_done", {a_rf_wen, a_retire, a_save_epc, a_tvalid}, 32'b1100);
        $display("lsu done: rf_wen=%0d retire=%0d cnt=%0d", a_rf_wen, a_retire, a_cnt);
        cyc();
        check("lsu_done_cnt", 32'(a_cnt), 32'd0);
        check("lsu_done_mcause", 32'(a_mcause), 32'd17);

        // LSU never completes: timeout at count 16
        clear_inputs();
        inst_valid_i = 1; lsu_en_i = 1;
        for (int i = 1; i <= 15; i++) begin
            cyc();
            check("tout_cnt", 32'(a_cnt), 32'(i));
            check("tout_wait_tv", 32'(a_tvalid), 32'd0);
        end
        cyc();
        check("tout_cnt16", 32'(a_cnt), 32'd16);
        check("tout_exc_pc", a_exc_pc, 32'h114);
        check("tout_ctrl", {a_pc_mux, a_save_epc, a_tvalid}, {28'd0, PC_EXCEPTION, 2'b11});
        $display("lsu timeout: cnt=%0d exc_pc=%h", a_cnt, a_exc_pc);
        cyc();
        check("tout_mcause", 32'(a_mcause), 32'd5);
        check("tout_cnt0", 32'(a_cnt), 32'd0);
        lsu_en_i = 0;
        #2;
        check("tout_idle", 32'(a_retire), 32'd1);
        cyc();

        // ecall and illegal
        clear_inputs();
        inst_valid_i = 1; ecall_inst_i = 1;
        #2;
        check("ecall_dir", b_exc_pc, 32'h200);
        check("ecall_vec", a_exc_pc, 32'h104);
        cyc();
        check("ecall_mcause", 32'(b_mcause), 32'd1);
        $display("ecall: mcause=%0d", b_mcause);
        ecall_inst_i = 0; illegal_inst_i = 1;
        #2;
        check("illegal_vec", a_exc_pc, 32'h108);
        cyc();
        check("illegal_mcause", 32'(b_mcause), 32'd2);
        $display("illegal: mcause=%0d", b_mcause);

        // Taken branch, then not-taken branch
        clear_inputs();
        inst_valid_i = 1; branch_inst_i = 1; comp_result_i = 1;
        #2;
        check("br_taken0", {a_retire, a_rf_wen, a_tvalid}, 32'b010);
        cyc();
        check("br_taken1", {a_retire, a_rf_wen, a_tvalid}, 32'b111);
        check("br_taken_cnt", 32'(a_cnt), 32'd1);
        $display("taken branch: retire=%0d target_valid=%0d", a_retire, a_tvalid);
        cyc();
        comp_result_i = 0;
        #2;
        check("br_not_taken", {a_retire, a_rf_wen, a_tvalid}, 32'b110);
        cyc();
        check("br_not_taken_cnt", 32'(a_cnt), 32'd0);

        // mret
        clear_inputs();
        inst_valid_i = 1; mret_inst_i = 1;
        #2;
        check("mret", {a_pc_mux, a_tvalid, a_retire, a_rf_wen}, {27'd0, PC_EPC, 3'b110});
        cyc();

        // LSU error at issue
        clear_inputs();
        inst_valid_i = 1; lsu_en_i = 1; lsu_err_i = 1;
        #2;
        check("lsu_err_pc", a_exc_pc, 32'h110);
        cyc();
        check("lsu_err_mcause", 32'(a_mcause), 32'd4);
        check("lsu_err_cnt", 32'(a_cnt), 32'd0);

        // ebreak halts; everything stays at defaults
        clear_inputs();
        inst_valid_i = 1; ebreak_inst_i = 1;
        #2;
        check("ebreak_retire", {a_retire, a_rf_wen}, 32'd0);
        cyc();
        check("halt_set", 32'(a_halt), 32'd1);
        ebreak_inst_i = 0; irq_i = 4'b1111; irq_en_i = 4'b1111; global_ie_i = 1;
        for (int i = 0; i < 10; i++) begin
            #2;
            check("halt_outs", {a_rf_wen, a_retire, a_tvalid, a_save_epc, a_pc_mux, a_ack},
                  32'd0);
            check("halt_exc_pc", a_exc_pc, 32'd0);
            cyc();
            check("halt_hold", 32'(a_halt), 32'd1);
        end
        $display("halt: halt=%0d held for 10 cycles", a_halt);

        // Reset leaves HALT; reset during an LSU wait abandons it
        clear_inputs();
        rst_n = 0;
        cyc();
        check("rst_halt_clr", 32'(a_halt), 32'd0);
        rst_n = 1; inst_valid_i = 1; lsu_en_i = 1;
        cyc();
        check("rst_lsu_cnt", 32'(a_cnt), 32'd1);
        rst_n = 0;
        cyc();
        check("rst_mid_cnt", 32'(a_cnt), 32'd0);
        check("rst_mid_halt", 32'(a_halt), 32'd0);
        check("rst_mid_mcause", 32'(a_mcause), 32'd0);
        rst_n = 1; lsu_en_i = 0;
        #2;
        check("rst_mid_idle", {a_retire, a_rf_wen, a_save_epc}, 32'b110);
        $display("reset mid-LSU: cnt=%0d halt=%0d retire=%0d", a_cnt, a_halt, a_retire);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
